// File: rtl/moore_event_counter.sv
// moore_event_counter
//
// Bank of N_CH independent Moore-style event counters. Each channel counts
// qualified events on its input bit. Its output is high while the count equals
// TERM. An event is either a high level or a rising edge, chosen by EDGE. At
// TERM the next event either wraps the count to 0 (WRAP=1) or is ignored
// (WRAP=0, sticky until clr).
//
// Ports:
//   clk      rising-edge clock for all state
//   rst      asynchronous active-low reset (clears counts, history, wrap pulse)
//   en       global count enable shared by every channel
//   clr      synchronous clear shared by every channel, beats en and events
//   in       event inputs, one bit per channel
//   out      per-channel decode of count == TERM (combinational from state)
//   count    per-channel count, channel i at bits [i*CNT_W +: CNT_W]
//   wrapped  registered one-cycle pulse after a TERM -> 0 wrap

module moore_event_counter #(
  parameter int N_CH  = 1,
  parameter int CNT_W = 2,
  parameter int TERM  = 3,
  parameter int EDGE  = 0,
  parameter int WRAP  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic [N_CH-1:0]         in,
  output logic [N_CH-1:0]         out,
  output logic [N_CH*CNT_W-1:0]   count,
  output logic [N_CH-1:0]         wrapped
);

  localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);

  // A terminal count of 0 or one that does not fit in CNT_W bits makes no
  // sense, so stop elaboration rather than build a counter that never fires.
  if (TERM < 1 || TERM > (2 ** CNT_W) - 1) begin : g_bad_term
    $error("moore_event_counter: TERM must lie in 1..2**CNT_W-1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] c;
    logic             wr;
    logic             ev;
    logic             over;

    // The edge history register is sampled every cycle, ignoring en and clr,
    // so an edge is always judged against the previous cycle's input.
    // After reset the history is 0, so an input that is already high counts
    // as one edge.
    if (EDGE != 0) begin : g_edge
      logic in_d;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) in_d <= 1'b0;
        else      in_d <= in[i];
      end
      assign ev = in[i] & ~in_d;
    end else begin : g_level
      assign ev = in[i];
    end

    // Counts above TERM cannot be reached in normal operation. They are
    // detected only when the register is wide enough to hold such a value.
    // Otherwise the compare would be constant false.
    if (TERM < (2 ** CNT_W) - 1) begin : g_over
      assign over = (c > TERM_C);
    end else begin : g_no_over
      assign over = 1'b0;
    end

    // Count update. clr has top priority, then en, then the event itself.
    // At TERM the event either wraps with a one-cycle pulse or is dropped.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        c  <= '0;
        wr <= 1'b0;
      end else begin
        wr <= 1'b0;
        if (clr || over) begin
          c <= '0;
        end else if (en && ev) begin
          if (c < TERM_C) begin
            c <= c + CNT_W'(1);
          end else if (WRAP != 0) begin
            c  <= '0;
            wr <= 1'b1;
          end
        end
      end
    end

    assign count[i*CNT_W +: CNT_W] = c;
    assign out[i]                  = (c == TERM_C);
    assign wrapped[i]              = wr;
  end

endmodule

// File: tb/tb_moore_event_counter.sv
// tb_moore_event_counter
//
// Self-checking bench for moore_event_counter. Four instances share clock,
// reset, enable and clear, and cover four configurations:
//   dutA: defaults (legacy detector, level, wrap, TERM=3)
//   dutB: edge mode, TERM=2, wrap
//   dutC: level mode, TERM=3, sticky
//   dutD: four channels, CNT_W=3, TERM=5, level, wrap
// The seven channels are numbered 0 (A), 1 (B), 2 (C) and 3..6 (D).
// A behavioural model is checked on every channel after every step.
// Directed sequences add fixed expected values.

module tb_moore_event_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic [6:0]  inVec;

  logic [0:0]  outA, outB, outC, wrA, wrB, wrC;
  logic [1:0]  cntA, cntB, cntC;
  logic [3:0]  outD, wrD;
  logic [11:0] cntD;

  int checks = 0;
  int errors = 0;

  // Reference model state for each channel.
  int termOf [7] = '{3, 2, 3, 5, 5, 5, 5};
  bit isEdge [7] = '{0, 1, 0, 0, 0, 0, 0};
  bit isWrap [7] = '{1, 1, 0, 1, 1, 1, 1};
  int modelCnt  [7];
  bit modelPrev [7];
  bit modelWr   [7];

  moore_event_counter dutA (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in(inVec[0:0]), .out(outA), .count(cntA), .wrapped(wrA)
  );

  moore_event_counter #(.TERM(2), .EDGE(1)) dutB (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in(inVec[1:1]), .out(outB), .count(cntB), .wrapped(wrB)
  );

  moore_event_counter #(.WRAP(0)) dutC (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in(inVec[2:2]), .out(outC), .count(cntC), .wrapped(wrC)
  );

  moore_event_counter #(.N_CH(4), .CNT_W(3), .TERM(5)) dutD (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in(inVec[6:3]), .out(outD), .count(cntD), .wrapped(wrD)
  );

  // Free-running clock, 10 time units per period, rising edges at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset puts every channel's model back to a zero count with no history.
  task automatic modelReset();
    for (int ch = 0; ch < 7; ch++) begin
      modelCnt[ch]  = 0;
      modelPrev[ch] = 1'b0;
      modelWr[ch]   = 1'b0;
    end
  endtask

  // One clock edge of the model. It uses the inputs as they were just before
  // the edge and applies the priority clear > enable > event > terminal rule.
  task automatic modelEdge(input logic [6:0] inV, input logic enV, input logic clrV);
    bit ev;
    for (int ch = 0; ch < 7; ch++) begin
      ev = isEdge[ch] ? (inV[ch] && !modelPrev[ch]) : inV[ch];
      modelPrev[ch] = inV[ch];
      modelWr[ch]   = 1'b0;
      if (clrV) begin
        modelCnt[ch] = 0;
      end else if (enV && ev) begin
        if (modelCnt[ch] < termOf[ch]) begin
          modelCnt[ch] = modelCnt[ch] + 1;
        end else if (isWrap[ch]) begin
          modelCnt[ch] = 0;
          modelWr[ch]  = 1'b1;
        end
      end
    end
  endtask

  // Single comparison point. It counts the check and reports a mismatch
  // through an immediate assertion.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Compare count, out and wrapped of every channel against the model.
  task automatic checkAll();
    int obsCnt, obsOut, obsWr;
    for (int ch = 0; ch < 7; ch++) begin
      case (ch)
        0: begin obsCnt = int'(cntA); obsOut = int'(outA); obsWr = int'(wrA); end
        1: begin obsCnt = int'(cntB); obsOut = int'(outB); obsWr = int'(wrB); end
        2: begin obsCnt = int'(cntC); obsOut = int'(outC); obsWr = int'(wrC); end
        default: begin
          obsCnt = int'(cntD[(ch-3)*3 +: 3]);
          obsOut = int'(outD[ch-3]);
          obsWr  = int'(wrD[ch-3]);
        end
      endcase
      checkOutput($sformatf("ch%0d count", ch), obsCnt, modelCnt[ch]);
      checkOutput($sformatf("ch%0d out", ch), obsOut, (modelCnt[ch] == termOf[ch]) ? 1 : 0);
      checkOutput($sformatf("ch%0d wrapped", ch), obsWr, int'(modelWr[ch]));
    end
  endtask

  // Drive one cycle of inputs and let one rising edge pass. The model then
  // advances, or stays in reset while rst is low, and the outputs are
  // checked 1 unit after the edge.
  task automatic applyStimulus(input logic [6:0] inV, input logic enV, input logic clrV);
    inVec = inV;
    en    = enV;
    clr   = clrV;
    @(posedge clk);
    if (!rst) modelReset();
    else      modelEdge(inV, enV, clrV);
    #1;
    checkAll();
  endtask

  // Pulse reset between clock edges. The outputs must clear at once, with no
  // clock edge, and reset is released well before the next edge.
  task automatic assertResetAsync();
    rst = 1'b0;
    #1;
    modelReset();
    checkAll();
    #2;
    rst = 1'b1;
  endtask

  // Directed sequences follow the intended use cases. A randomized phase
  // then mixes inputs, enable, clear and occasional resets.
  initial begin
    int expA [8] = '{1, 1, 2, 2, 2, 3, 0, 0};
    int expB [8] = '{1, 1, 1, 1, 2, 2, 2, 0};
    int seqA [8] = '{1, 0, 1, 0, 0, 1, 1, 0};
    int seqB [8] = '{1, 1, 1, 0, 1, 0, 0, 1};
    int expD [8] = '{1, 2, 2, 2, 3, 4, 5, 0};
    logic [6:0] v;

    // Reset held with every input high and enable on. Nothing may move.
    rst   = 1'b0;
    en    = 1'b1;
    clr   = 1'b0;
    inVec = 7'h7F;
    modelReset();
    #1;
    checkAll();
    applyStimulus(7'h7F, 1'b1, 1'b0);
    applyStimulus(7'h7F, 1'b1, 1'b0);
    #2;
    rst = 1'b1;

    // After release, level mode with TERM=3 walks 1, 2, 3, 0.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(7'h7F, 1'b1, 1'b0);
      checkOutput("reset release A count", int'(cntA), (k + 1) % 4);
    end
    checkOutput("reset release A wrapped", int'(wrA), 1);

    // Legacy sequence on A and the edge sequence on B, run side by side.
    applyStimulus(7'h00, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      v = 7'h00;
      v[0] = seqA[k][0];
      v[1] = seqB[k][0];
      applyStimulus(v, 1'b1, 1'b0);
      checkOutput("legacy A count", int'(cntA), expA[k]);
      checkOutput("edge B count", int'(cntB), expB[k]);
    end
    checkOutput("edge B wrapped", int'(wrB), 1);

    // Sticky channel C saturates at 3 and never pulses wrapped.
    applyStimulus(7'h00, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(7'h04, 1'b1, 1'b0);
      checkOutput("sticky C count", int'(cntC), (k < 3) ? k + 1 : 3);
      checkOutput("sticky C wrapped", int'(wrC), 0);
    end
    applyStimulus(7'h04, 1'b1, 1'b1);
    checkOutput("sticky C clear beats event", int'(cntC), 0);

    // Four-channel bank with all inputs high and enable dropped on cycles
    // 2 and 3. All channels reach 5 together and wrap together.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(7'h78, (k == 2 || k == 3) ? 1'b0 : 1'b1, 1'b0);
      checkOutput("bank D ch0 count", int'(cntD[2:0]), expD[k]);
      checkOutput("bank D ch3 count", int'(cntD[11:9]), expD[k]);
    end
    checkOutput("bank D wrapped", int'(wrD), 15);

    // Only channels 0 and 2 of the bank see events.
    applyStimulus(7'h00, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) applyStimulus({4'b0101, 3'b000}, 1'b1, 1'b0);
    checkOutput("bank D pattern out", int'(outD), 5);
    checkOutput("bank D ch1 idle", int'(cntD[5:3]), 0);

    // Reset arriving mid-count, between edges, wipes progress at once.
    applyStimulus(7'h00, 1'b1, 1'b1);
    applyStimulus(7'h01, 1'b1, 1'b0);
    applyStimulus(7'h01, 1'b1, 1'b0);
    checkOutput("mid-count A count", int'(cntA), 2);
    assertResetAsync();
    checkOutput("async reset A count", int'(cntA), 0);
    applyStimulus(7'h01, 1'b1, 1'b0);
    checkOutput("resume after reset A count", int'(cntA), 1);

    // Random traffic checked against the model on every step.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(59) == 0) begin
        assertResetAsync();
      end else begin
        applyStimulus(7'($urandom), ($urandom_range(7) != 0) ? 1'b1 : 1'b0,
                      ($urandom_range(19) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
